// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } slice_state_e;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMWRITE = 1;
   localparam int CTRL_JUMP     = 2;
   localparam int CTRL_BRANCH   = 3;

   localparam int DEPTH_MAX = 4;

endpackage

// File: rtl/pipe_skid_slice.sv
// One skid slice: a main register plus a skid register, so in_ready never
// depends combinationally on out_ready.
module pipe_skid_slice
   import pipe_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic              occupied
);

   slice_state_e      state_reg;
   logic [CTRL_W-1:0] main_ctrl_reg;
   logic [CTRL_W-1:0] skid_ctrl_reg;
   logic [DATA_W-1:0] main_data_reg;
   logic [DATA_W-1:0] skid_data_reg;
   logic              go;
   logic              in_fire;
   logic              out_fire;

   // Stall, flush and reset all block transfers in both directions.
   assign go        = rst_n & ~stall & ~flush;
   assign in_ready  = (state_reg != SKID) & go;
   assign out_valid = (state_reg != EMPTY) & go;
   assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
   assign out_data  = main_data_reg;
   assign occupied  = (state_reg != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= EMPTY;
         main_ctrl_reg <= '0;
         skid_ctrl_reg <= '0;
         main_data_reg <= '0;
         skid_data_reg <= '0;
      end else if (flush) begin
         // Squashed entries lose their side-effect bits; data may linger.
         state_reg     <= EMPTY;
         main_ctrl_reg <= '0;
         skid_ctrl_reg <= '0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_fire) begin
                  main_ctrl_reg <= in_ctrl;
                  main_data_reg <= in_data;
                  state_reg     <= FULL;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_ctrl_reg <= in_ctrl;
                  main_data_reg <= in_data;
               end else if (in_fire) begin
                  skid_ctrl_reg <= in_ctrl;
                  skid_data_reg <= in_data;
                  state_reg     <= SKID;
               end else if (out_fire) begin
                  main_ctrl_reg <= '0;
                  state_reg     <= EMPTY;
               end
            end
            SKID: begin
               if (out_fire) begin
                  main_ctrl_reg <= skid_ctrl_reg;
                  main_data_reg <= skid_data_reg;
                  skid_ctrl_reg <= '0;
                  state_reg     <= FULL;
               end
            end
            default: state_reg <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: DEPTH cascaded skid slices with valid/ready,
// stall and flush. Define PIPE_STAGE_PERF_EN to add saturating perf counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 8,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_kills,
   output logic [CNT_W-1:0]  bp_cycles
`endif
);

   // Out-of-range DEPTH is clamped into 1..DEPTH_MAX.
   localparam int NSLICE = (DEPTH < 1) ? 1 : ((DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH);

   logic              chain_valid [0:NSLICE];
   logic              chain_ready [0:NSLICE];
   logic [CTRL_W-1:0] chain_ctrl  [0:NSLICE];
   logic [DATA_W-1:0] chain_data  [0:NSLICE];
   logic [NSLICE-1:0] occupied;

   assign chain_valid[0]      = in_valid;
   assign chain_ctrl[0]       = in_ctrl;
   assign chain_data[0]       = in_data;
   assign in_ready            = chain_ready[0];
   assign chain_ready[NSLICE] = out_ready;
   assign out_valid           = chain_valid[NSLICE];
   assign out_ctrl            = chain_ctrl[NSLICE];
   assign out_data            = chain_data[NSLICE];

   for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      pipe_skid_slice #(
         .DATA_W (DATA_W),
         .CTRL_W (CTRL_W)
      ) u_slice (
         .clk       (clk),
         .rst_n     (rst_n),
         .stall     (stall),
         .flush     (flush),
         .in_valid  (chain_valid[gi]),
         .in_ready  (chain_ready[gi]),
         .in_ctrl   (chain_ctrl[gi]),
         .in_data   (chain_data[gi]),
         .out_valid (chain_valid[gi+1]),
         .out_ready (chain_ready[gi+1]),
         .out_ctrl  (chain_ctrl[gi+1]),
         .out_data  (chain_data[gi+1]),
         .occupied  (occupied[gi])
      );
   end

`ifdef PIPE_STAGE_PERF_EN
   // Counters saturate and are cleared only by reset, never by flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_kills  <= '0;
         bp_cycles    <= '0;
      end else begin
         if (stall && !flush && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (flush && (|occupied) && (flush_kills != '1))
            flush_kills <= flush_kills + 1'b1;
         if (out_valid && !out_ready && (bp_cycles != '1))
            bp_cycles <= bp_cycles + 1'b1;
      end
   end
`else
   localparam int CNT_W_UNUSED = CNT_W;
   logic occupied_unused;
   assign occupied_unused = |occupied;
`endif

endmodule
